hangman_round_ctrl: RTL and testbench
=====================================

Name: hangman_round_ctrl

Overview:
- Parametrised next-generation game controller for the hangman design. It sits between the keyboard/letter decoder and the display/score logic.
- It owns the game FSM, the guessed-letter and wrong-letter masks, the lives counter, and the session win/loss tallies.
- Alphabet size, life count and score width are generalised as parameters.
- New relative to the previous generation: repeated-guess detection with no life penalty, invalid-code rejection, empty-word rejection, and session scoring.
- Fully synchronous: every register is clocked by clk. There are no derived clocks and no combinational feedback from state.

Parameters:
ALPHA, 26, number of letters; letter codes 0..ALPHA-1, code ALPHA = start command
LIVES, 5, wrong guesses allowed per round (1..15)
SCORE_W, 8, width of win/loss tally counters
CODE_W, $clog2(ALPHA+1), width of load_x (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
load  in  1  one-cycle strobe qualifying load_x
load_x  in  CODE_W  letter code or start command
mask  in  ALPHA  letter set of the secret word; sampled only on an accepted start
guessed_mask  out  ALPHA  correctly guessed letters
wrong_mask  out  ALPHA  wrongly guessed letters
game_state  out  2  0 START, 1 INGAME, 2 WIN, 3 LOST
lives_left  out  4  remaining wrong guesses
wrong  out  1  one-cycle pulse on a new wrong guess
repeat_guess  out  1  one-cycle pulse on a repeated letter
win_count  out  SCORE_W  rounds won since reset
loss_count  out  SCORE_W  rounds lost since reset

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - game_state=START, all masks=0, word register=0, lives_left=LIVES;
  - wrong=0, repeat_guess=0, win_count=0, loss_count=0.
- All outputs are registered. A load sampled at edge N is reflected in the outputs after edge N; pulses are high for exactly that one cycle.
- Accepted start: load=1, load_x==ALPHA and mask!=0, in any state, including mid-round.
  - Word register <= mask; guessed_mask and wrong_mask <= 0; lives_left <= LIVES; state <= INGAME.
  - Tallies are unchanged. Aborting a round mid-play does not count as a loss.
- Start with mask==0 is ignored: the state and all registers are unchanged.
- load_x > ALPHA is ignored in every state.
- Letter guess: load=1, load_x<ALPHA, state INGAME. Let b = bit load_x.
  - b set in guessed_mask or wrong_mask: repeat_guess pulse; nothing else changes.
  - Else if b set in the word register: set b in guessed_mask. If (guessed_mask | b) == word register, then state <= WIN and win_count += 1 on the same edge.
  - Else: set b in wrong_mask, wrong pulse, lives_left -= 1. If lives_left was 1, then state <= LOST and loss_count += 1 on the same edge.
- Letter guesses in START, WIN or LOST are ignored: no pulses, no change.
- WIN and LOST are held until an accepted start or reset. The masks remain visible for display.
- Tallies saturate at 2^SCORE_W-1; they never wrap.
- lives_left never underflows; it is 0 only in LOST.
- Masks outside the word register are don't-care. Only bits 0..ALPHA-1 exist.

Decomposition:
- Shared package hangman_pkg holds:
  - the game_state encodings (ST_START, ST_INGAME, ST_WIN, ST_LOST);
  - a function computing CODE_W from ALPHA;
  - the start-command code (ALPHA).
- One sub-module, guess_eval, is purely combinational. Inputs: load_x, word, guessed_mask, wrong_mask. Outputs: is_valid_letter, is_repeat, is_hit, completes_word (one-hot decode and the compare).
- hangman_round_ctrl keeps the FSM, counters and all registers.

Test Plan:
- Reset mid-round: release reset with load idle -> START, lives_left=5, masks 0, counts 0. Then assert reset asynchronously in INGAME with lives_left=3 -> immediate return to those values, without waiting for a clk edge.
- Win path: start with mask={A,B} (bits 0,1) -> INGAME. Guess 0 -> guessed_mask=...011? no: guessed_mask=1; guess 1 -> guessed_mask=3, game_state=2, win_count=1, lives_left=5.
- Loss path: start with mask=bit 4. Guess letters 0,1,2,3,5 -> five wrong pulses, lives_left 4,3,2,1,0; after the fifth guess game_state=3 and loss_count=1. A further guess of 4 is ignored.
- Repeat handling: in INGAME, guess 7 (wrong) twice, then a hit letter twice -> wrong pulse once and repeat_guess pulse twice; lives_left drops by exactly 1.
- Invalid inputs: start with mask=0 -> stays START. load_x=31 in INGAME -> no change, no pulse. Letter load in WIN -> no change.
- Restart/saturation (SCORE_W=2): win 4 rounds back-to-back via start from WIN -> win_count sequence 1,2,3,3. A start issued mid-round clears the masks and sets lives_left to 5, with loss_count unchanged.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman round controller.
//   game_state_t  : encoding of the game_state output
//   calc_code_w   : width of a letter/command code for a given alphabet size
//   start_code    : code value that means "start a new round"
package hangman_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_INGAME = 2'd1,
        ST_WIN    = 2'd2,
        ST_LOST   = 2'd3
    } game_state_t;

    // Codes 0..alpha-1 are letters and code alpha is the start command,
    // so alpha+1 distinct values must be representable.
    function automatic int calc_code_w(input int alpha);
        return $clog2(alpha + 1);
    endfunction

    function automatic int start_code(input int alpha);
        return alpha;
    endfunction

endpackage

// File: rtl/hangman_round_ctrl_guess_eval.sv
// Combinational evaluation of one letter guess against the round state.
// Ports:
//   load_x          in   letter code (or command) being presented
//   word            in   letter set of the secret word
//   guessed_mask    in   letters already guessed correctly
//   wrong_mask      in   letters already guessed wrongly
//   is_valid_letter out  load_x is a letter code (< ALPHA)
//   is_repeat       out  letter was already guessed (right or wrong)
//   is_hit          out  new letter that is in the word
//   completes_word  out  new hit that makes guessed_mask equal to word
//   letter_onehot   out  one-hot decode of load_x (zero for non-letters)
module guess_eval
    import hangman_pkg::*;
#(
    parameter int ALPHA  = 26,
    parameter int CODE_W = calc_code_w(ALPHA)
) (
    input  logic [CODE_W-1:0] load_x,
    input  logic [ALPHA-1:0]  word,
    input  logic [ALPHA-1:0]  guessed_mask,
    input  logic [ALPHA-1:0]  wrong_mask,
    output logic              is_valid_letter,
    output logic              is_repeat,
    output logic              is_hit,
    output logic              completes_word,
    output logic [ALPHA-1:0]  letter_onehot
);

    always_comb begin
        letter_onehot = '0;
        for (int unsigned i = 0; i < ALPHA; i++) begin
            letter_onehot[i] = (load_x == CODE_W'(i));
        end

        is_valid_letter = (load_x < CODE_W'(ALPHA));
        is_repeat       = |(letter_onehot & (guessed_mask | wrong_mask));
        is_hit          = !is_repeat && (|(letter_onehot & word));
        completes_word  = is_hit && ((guessed_mask | letter_onehot) == word);
    end

endmodule

// File: rtl/hangman_round_ctrl.sv
// Hangman round controller: game FSM, guessed/wrong letter masks, lives
// counter and saturating session win/loss tallies.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   load         in   one-cycle strobe qualifying load_x
//   load_x       in   letter code 0..ALPHA-1, or ALPHA = start command
//   mask         in   secret word letter set, taken on an accepted start
//   guessed_mask out  correctly guessed letters
//   wrong_mask   out  wrongly guessed letters
//   game_state   out  0 START, 1 INGAME, 2 WIN, 3 LOST
//   lives_left   out  remaining wrong guesses
//   wrong        out  one-cycle pulse on a new wrong guess
//   repeat_guess out  one-cycle pulse on a repeated letter
//   win_count    out  rounds won since reset (saturating)
//   loss_count   out  rounds lost since reset (saturating)
module hangman_round_ctrl
    import hangman_pkg::*;
#(
    parameter int ALPHA   = 26,
    parameter int LIVES   = 5,
    parameter int SCORE_W = 8,
    parameter int CODE_W  = calc_code_w(ALPHA)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [CODE_W-1:0]  load_x,
    input  logic [ALPHA-1:0]   mask,
    output logic [ALPHA-1:0]   guessed_mask,
    output logic [ALPHA-1:0]   wrong_mask,
    output logic [1:0]         game_state,
    output logic [3:0]         lives_left,
    output logic               wrong,
    output logic               repeat_guess,
    output logic [SCORE_W-1:0] win_count,
    output logic [SCORE_W-1:0] loss_count
);

    localparam logic [CODE_W-1:0] START_CMD  = CODE_W'(start_code(ALPHA));
    localparam logic [3:0]        LIVES_INIT = 4'(LIVES);

    game_state_t        state_q, state_d;
    logic [ALPHA-1:0]   word_q;
    logic [ALPHA-1:0]   guessed_q;
    logic [ALPHA-1:0]   wrong_mask_q;
    logic [3:0]         lives_q;
    logic               wrong_q;
    logic               repeat_q;
    logic [SCORE_W-1:0] win_q;
    logic [SCORE_W-1:0] loss_q;

    logic               is_valid_letter;
    logic               is_repeat;
    logic               is_hit;
    logic               completes_word;
    logic [ALPHA-1:0]   letter_onehot;

    logic               ev_start;
    logic               ev_letter;
    logic               ev_repeat;
    logic               ev_hit;
    logic               ev_miss;
    logic               ev_win;
    logic               ev_lose;

    guess_eval #(
        .ALPHA  (ALPHA),
        .CODE_W (CODE_W)
    ) u_guess_eval (
        .load_x          (load_x),
        .word            (word_q),
        .guessed_mask    (guessed_q),
        .wrong_mask      (wrong_mask_q),
        .is_valid_letter (is_valid_letter),
        .is_repeat       (is_repeat),
        .is_hit          (is_hit),
        .completes_word  (completes_word),
        .letter_onehot   (letter_onehot)
    );

    // Event decode. Codes above ALPHA match neither a start nor a letter
    // and therefore fall through as no-ops in every state.
    always_comb begin
        ev_start  = load && (load_x == START_CMD) && (mask != '0);
        ev_letter = load && is_valid_letter && (state_q == ST_INGAME);
        ev_repeat = ev_letter && is_repeat;
        ev_hit    = ev_letter && is_hit;
        ev_miss   = ev_letter && !is_repeat && !is_hit;
        ev_win    = ev_hit && completes_word;
        ev_lose   = ev_miss && (lives_q == 4'd1);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start wins from any state, including mid-round
    always_comb begin
        state_d = state_q;
        if (ev_start) begin
            state_d = ST_INGAME;
        end else if (ev_win) begin
            state_d = ST_WIN;
        end else if (ev_lose) begin
            state_d = ST_LOST;
        end
    end

    // Round datapath and tallies
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q       <= '0;
            guessed_q    <= '0;
            wrong_mask_q <= '0;
            lives_q      <= LIVES_INIT;
            wrong_q      <= 1'b0;
            repeat_q     <= 1'b0;
            win_q        <= '0;
            loss_q       <= '0;
        end else begin
            wrong_q  <= ev_miss;
            repeat_q <= ev_repeat;

            if (ev_start) begin
                word_q       <= mask;
                guessed_q    <= '0;
                wrong_mask_q <= '0;
                lives_q      <= LIVES_INIT;
            end else begin
                if (ev_hit) begin
                    guessed_q <= guessed_q | letter_onehot;
                end
                if (ev_miss) begin
                    wrong_mask_q <= wrong_mask_q | letter_onehot;
                    lives_q      <= lives_q - 4'd1;
                end
            end

            if (ev_win && (win_q != '1)) begin
                win_q <= win_q + SCORE_W'(1);
            end
            if (ev_lose && (loss_q != '1)) begin
                loss_q <= loss_q + SCORE_W'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        game_state   = state_q;
        guessed_mask = guessed_q;
        wrong_mask   = wrong_mask_q;
        lives_left   = lives_q;
        wrong        = wrong_q;
        repeat_guess = repeat_q;
        win_count    = win_q;
        loss_count   = loss_q;
    end

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Self-checking bench for hangman_round_ctrl (ALPHA=26, LIVES=5, SCORE_W=2).
module tb_hangman_round_ctrl;

    localparam int ALPHA   = 26;
    localparam int SCORE_W = 2;
    localparam int START   = 26;

    logic               clk;
    logic               reset;
    logic               load;
    logic [4:0]         load_x;
    logic [25:0]        mask;
    logic [25:0]        guessed_mask;
    logic [25:0]        wrong_mask;
    logic [1:0]         game_state;
    logic [3:0]         lives_left;
    logic               wrong;
    logic               repeat_guess;
    logic [SCORE_W-1:0] win_count;
    logic [SCORE_W-1:0] loss_count;

    hangman_round_ctrl #(
        .ALPHA   (ALPHA),
        .LIVES   (5),
        .SCORE_W (SCORE_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .load_x       (load_x),
        .mask         (mask),
        .guessed_mask (guessed_mask),
        .wrong_mask   (wrong_mask),
        .game_state   (game_state),
        .lives_left   (lives_left),
        .wrong        (wrong),
        .repeat_guess (repeat_guess),
        .win_count    (win_count),
        .loss_count   (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         ld;
        logic [4:0]   x;
        logic [25:0]  m;
        logic [25:0]  g;
        logic [25:0]  w;
        logic [1:0]   st;
        logic [3:0]   lv;
        logic         wr;
        logic         rp;
        logic [1:0]   wc;
        logic [1:0]   lc;
    } vec_t;

    vec_t table_q[$];
    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(string n, bit ld, int x, logic [25:0] m,
                                logic [25:0] g, logic [25:0] w, int st, int lv,
                                bit wr, bit rp, int wc, int lc);
        vec_t v;
        v.name = n;  v.ld = ld;     v.x  = 5'(x);  v.m  = m;
        v.g    = g;  v.w  = w;      v.st = 2'(st); v.lv = 4'(lv);
        v.wr   = wr; v.rp = rp;     v.wc = 2'(wc); v.lc = 2'(lc);
        return v;
    endfunction

    task automatic check_out();
        vec_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = exp_q.pop_front();
        if ({guessed_mask, wrong_mask, game_state, lives_left, wrong, repeat_guess,
             win_count, loss_count} !==
            {e.g, e.w, e.st, e.lv, e.wr, e.rp, e.wc, e.lc}) begin
            failures++;
            $display("FAIL %s: got g=%h w=%h st=%0d lives=%0d wr=%b rep=%b win=%0d loss=%0d, want g=%h w=%h st=%0d lives=%0d wr=%b rep=%b win=%0d loss=%0d",
                     e.name, guessed_mask, wrong_mask, game_state, lives_left, wrong,
                     repeat_guess, win_count, loss_count,
                     e.g, e.w, e.st, e.lv, e.wr, e.rp, e.wc, e.lc);
        end
    endtask

    // Drive one vector, queue its expectation, then sample 1 time unit
    // after the edge that captures it.
    task automatic step(input vec_t v);
        load   = v.ld;
        load_x = v.x;
        mask   = v.m;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        load = 1'b0;
        check_out();
    endtask

    initial begin
        reset  = 1'b0;
        load   = 1'b0;
        load_x = '0;
        mask   = '0;

        //           name            ld  x   mask     guessed  wrong    st lv wr rp wc lc
        table_q.push_back(mk("idle_after_rst", 0, 0,  26'h0,   26'h0,   26'h0,   0, 5, 0, 0, 0, 0));
        table_q.push_back(mk("start_mask0",    1, START, 26'h0, 26'h0,  26'h0,   0, 5, 0, 0, 0, 0));
        table_q.push_back(mk("letter_in_start",1, 0,  26'h0,   26'h0,   26'h0,   0, 5, 0, 0, 0, 0));
        table_q.push_back(mk("start_ab",       1, START, 26'h3, 26'h0,  26'h0,   1, 5, 0, 0, 0, 0));
        table_q.push_back(mk("hit_a",          1, 0,  26'h0,   26'h1,   26'h0,   1, 5, 0, 0, 0, 0));
        table_q.push_back(mk("code31_ignored", 1, 31, 26'h0,   26'h1,   26'h0,   1, 5, 0, 0, 0, 0));
        table_q.push_back(mk("hit_b_win",      1, 1,  26'h0,   26'h3,   26'h0,   2, 5, 0, 0, 1, 0));
        table_q.push_back(mk("letter_in_win",  1, 5,  26'h0,   26'h3,   26'h0,   2, 5, 0, 0, 1, 0));
        table_q.push_back(mk("start_e",        1, START, 26'h10, 26'h0, 26'h0,   1, 5, 0, 0, 1, 0));
        table_q.push_back(mk("miss_0",         1, 0,  26'h0,   26'h0,   26'h1,   1, 4, 1, 0, 1, 0));
        table_q.push_back(mk("miss_1",         1, 1,  26'h0,   26'h0,   26'h3,   1, 3, 1, 0, 1, 0));
        table_q.push_back(mk("miss_2",         1, 2,  26'h0,   26'h0,   26'h7,   1, 2, 1, 0, 1, 0));
        table_q.push_back(mk("miss_3",         1, 3,  26'h0,   26'h0,   26'hF,   1, 1, 1, 0, 1, 0));
        table_q.push_back(mk("miss_5_lost",    1, 5,  26'h0,   26'h0,   26'h2F,  3, 0, 1, 0, 1, 1));
        table_q.push_back(mk("letter_in_lost", 1, 4,  26'h0,   26'h0,   26'h2F,  3, 0, 0, 0, 1, 1));
        table_q.push_back(mk("start_c_j",      1, START, 26'h204, 26'h0, 26'h0,  1, 5, 0, 0, 1, 1));
        table_q.push_back(mk("miss_7",         1, 7,  26'h0,   26'h0,   26'h80,  1, 4, 1, 0, 1, 1));
        table_q.push_back(mk("start0_ingame",  1, START, 26'h0, 26'h0,  26'h80,  1, 4, 0, 0, 1, 1));
        table_q.push_back(mk("repeat_7",       1, 7,  26'h0,   26'h0,   26'h80,  1, 4, 0, 1, 1, 1));
        table_q.push_back(mk("hit_2",          1, 2,  26'h0,   26'h4,   26'h80,  1, 4, 0, 0, 1, 1));
        table_q.push_back(mk("repeat_2",       1, 2,  26'h0,   26'h4,   26'h80,  1, 4, 0, 1, 1, 1));
        table_q.push_back(mk("idle_pulse_off", 0, 2,  26'h0,   26'h4,   26'h80,  1, 4, 0, 0, 1, 1));
        table_q.push_back(mk("code28_ignored", 1, 28, 26'h0,   26'h4,   26'h80,  1, 4, 0, 0, 1, 1));
        table_q.push_back(mk("start_midround", 1, START, 26'h3, 26'h0,  26'h0,   1, 5, 0, 0, 1, 1));
        table_q.push_back(mk("hit_a2",         1, 0,  26'h0,   26'h1,   26'h0,   1, 5, 0, 0, 1, 1));
        table_q.push_back(mk("hit_b2_win",     1, 1,  26'h0,   26'h3,   26'h0,   2, 5, 0, 0, 2, 1));
        table_q.push_back(mk("start_from_win", 1, START, 26'h1, 26'h0,  26'h0,   1, 5, 0, 0, 2, 1));
        table_q.push_back(mk("win3",           1, 0,  26'h0,   26'h1,   26'h0,   2, 5, 0, 0, 3, 1));
        table_q.push_back(mk("start_again",    1, START, 26'h1, 26'h0,  26'h0,   1, 5, 0, 0, 3, 1));
        table_q.push_back(mk("win_saturate",   1, 0,  26'h0,   26'h1,   26'h0,   2, 5, 0, 0, 3, 1));

        // Reset value, held asynchronously before any clock-driven update
        #12;
        exp_q.push_back(mk("reset_held", 0, 0, 26'h0, 26'h0, 26'h0, 0, 5, 0, 0, 0, 0));
        check_out();
        reset = 1'b1;

        for (int i = 0; i < table_q.size(); i++) begin
            step(table_q[i]);
        end

        // Asynchronous reset in INGAME with three lives left
        step(mk("pre_rst_start", 1, START, 26'h10, 26'h0, 26'h0, 1, 5, 0, 0, 3, 1));
        step(mk("pre_rst_miss0", 1, 0, 26'h0, 26'h0, 26'h1, 1, 4, 1, 0, 3, 1));
        step(mk("pre_rst_miss1", 1, 1, 26'h0, 26'h0, 26'h3, 1, 3, 1, 0, 3, 1));
        reset = 1'b0;
        #1;
        exp_q.push_back(mk("async_reset", 0, 0, 26'h0, 26'h0, 26'h0, 0, 5, 0, 0, 0, 0));
        check_out();
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back wins from a clean tally: 1,2,3,3
        for (int r = 1; r <= 4; r++) begin
            step(mk("sat_start", 1, START, 26'h1, 26'h0, 26'h0, 1, 5, 0, 0, (r > 3) ? 3 : r - 1, 0));
            step(mk("sat_win",   1, 0, 26'h0, 26'h1, 26'h0, 2, 5, 0, 0, (r > 3) ? 3 : r, 0));
        end

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: got %0d pending, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
